// File: rtl/sec_display3_pkg.sv
// Shared types and constants for the sec_display3 M:SS stopwatch.
package sec_disp_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned BCD_W  = 4;
  localparam int unsigned SCAN_W = 3;
  localparam int unsigned DIG_N  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Scan slot assignment
  localparam logic [SCAN_W-1:0] DIG_SU = 3'd0;
  localparam logic [SCAN_W-1:0] DIG_ST = 3'd1;
  localparam logic [SCAN_W-1:0] DIG_MN = 3'd2;

  // BCD increment that wraps to 0 after max_v
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] max_v);
    return (v >= max_v) ? BCD_W'(0) : BCD_W'(v + BCD_W'(1));
  endfunction

endpackage

// File: rtl/sec_display3_seg7_dec.sv
// Combinational BCD to 7-segment decoder; codes 10..15 decode to blank.
module seg7_dec
  import sec_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  // Pattern lookup
  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sec_display3.sv
// Three-digit M:SS stopwatch with scanned 7-segment output.
// Optional macro SEC_DISPLAY3_DP_EN adds a blinking separator output dp
// on the minutes digit while running.
module sec_display3
  import sec_disp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_run,
  input  logic              btn_clr,
  input  logic [SCAN_W-1:0] scan,
  output logic [SEG_W-1:0]  seg,
  output logic [DIG_N-1:0]  dig_en,
  output logic              clr_scan,
  output logic              ovf
`ifdef SEC_DISPLAY3_DP_EN
  ,
  output logic              dp
`endif
);

  localparam int unsigned      PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           state;
  logic [PRE_W-1:0] presc;
  logic [BCD_W-1:0] su;
  logic [BCD_W-1:0] st;
  logic [BCD_W-1:0] mn;
  logic             btn_run_q;
  logic             btn_clr_q;
  logic             run_edge;
  logic             clr_edge;
  logic             tick;
  logic [BCD_W-1:0] digit_c;
  logic [DIG_N-1:0] dig_en_c;
  logic [SEG_W-1:0] seg_c;

  assign run_edge = btn_run & ~btn_run_q;
  assign clr_edge = btn_clr & ~btn_clr_q;
  assign tick     = (state == RUN) && (presc == PRE_MAX);

  // Button history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_run_q <= 1'b0;
      btn_clr_q <= 1'b0;
    end else begin
      btn_run_q <= btn_run;
      btn_clr_q <= btn_clr;
    end
  end

  // Run/pause FSM; clear wins over a simultaneous run edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clr_scan <= 1'b0;
    end else begin
      clr_scan <= clr_edge;
      if (clr_edge) begin
        state <= IDLE;
      end else if (run_edge) begin
        case (state)
          IDLE:    state <= RUN;
          RUN:     state <= PAUSE;
          PAUSE:   state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Prescaler and BCD time digits with sticky wrap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      su    <= '0;
      st    <= '0;
      mn    <= '0;
      ovf   <= 1'b0;
    end else if (clr_edge) begin
      presc <= '0;
      su    <= '0;
      st    <= '0;
      mn    <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        RUN:     presc <= tick ? '0 : PRE_W'(presc + PRE_W'(1));
        PAUSE:   presc <= presc;
        default: presc <= '0;
      endcase
      if (tick) begin
        su <= bcd_inc(su, 4'd9);
        if (su == 4'd9) begin
          st <= bcd_inc(st, 4'd5);
          if (st == 4'd5) begin
            mn <= bcd_inc(mn, 4'd9);
            if (mn == 4'd9) ovf <= 1'b1;
          end
        end
      end
    end
  end

  // Digit select from scan slot; out-of-range slots feed a blank code
  always_comb begin
    digit_c  = 4'hF;
    dig_en_c = 3'b000;
    case (scan)
      DIG_SU: begin digit_c = su; dig_en_c = 3'b001; end
      DIG_ST: begin digit_c = st; dig_en_c = 3'b010; end
      DIG_MN: begin digit_c = mn; dig_en_c = 3'b100; end
      default: begin digit_c = 4'hF; dig_en_c = 3'b000; end
    endcase
  end

  seg7_dec u_dec (
    .bcd   (digit_c),
    .seg_c (seg_c)
  );

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= SEG_BLANK;
      dig_en <= 3'b000;
    end else begin
      seg    <= seg_c;
      dig_en <= dig_en_c;
    end
  end

`ifdef SEC_DISPLAY3_DP_EN
  // Separator lit for the first half of each second on the minutes slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp <= 1'b0;
    end else begin
      dp <= (scan == DIG_MN) && (state == RUN) && (presc < PRE_W'(TICK_DIV / 2));
    end
  end
`endif

endmodule
